uart_rx_param: RTL and testbench

Parametrised UART receive front end: oversampled start-bit qualification, configurable data width, stop-bit count and optional parity, majority-vote bit sampling, and a ready/valid output register with framing and overrun reporting. It sits between the board `rxd` pin and the CPU's memory-mapped I/O or receive FIFO. It is the successor of the fixed 8N1, 16x-oversampled receiver.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_param.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, majority-vote phases and default baud constants.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_t;

    // 50 MHz system clock, 115200 baud, 16x oversampling.
    localparam int unsigned DEFAULT_OVERSAMPLE    = 16;
    localparam int unsigned DEFAULT_CLKS_PER_TICK = 27;

    function automatic int unsigned vote_first(input int unsigned oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int unsigned vote_mid(input int unsigned oversample);
        return oversample / 2;
    endfunction

    function automatic int unsigned vote_last(input int unsigned oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every CLKS_PER_TICK clocks, held at zero by clear.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_TICK = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_TICK);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(CLKS_PER_TICK - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with ready/valid output, framing and overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned OVERSAMPLE    = DEFAULT_OVERSAMPLE,
    parameter int unsigned CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK,
    parameter int unsigned STOP_BITS     = 1,
    parameter bit          PARITY_ODD    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned PW = $clog2(OVERSAMPLE);

    uart_rx_state_t state_q, state_d;
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q, fall_q;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] samp_q, samp_d;
    logic [DATA_BITS-1:0] data_q, data_d, dout_q, dout_d;
    logic ferr_q, ferr_d, dout_vld_q, dout_vld_d, frame_err_q, frame_err_d, overrun_q;
    logic tick, at_first, at_mid, at_last, at_wrap, vote, deliver, deliver_ferr, load;
`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d, parity_err_q, parity_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            fall_q     <= rxd_prev_q & ~rxd_sync_q;
        end
    end

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == StIdle),
        .tick (tick)
    );

    assign at_first = tick && (phase_q == PW'(vote_first(OVERSAMPLE)));
    assign at_mid   = tick && (phase_q == PW'(vote_mid(OVERSAMPLE)));
    assign at_last  = tick && (phase_q == PW'(vote_last(OVERSAMPLE)));
    assign at_wrap  = tick && (phase_q == PW'(OVERSAMPLE - 1));
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) |
                      (samp_q[1] & rxd_sync_q);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        data_d       = data_q;
        ferr_d       = ferr_q;
        deliver      = 1'b0;
        deliver_ferr = ferr_q | ~vote;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
`endif
        if (tick) begin
            phase_d = at_wrap ? '0 : phase_q + 1'b1;
        end
        if (at_first) samp_d[0] = rxd_sync_q;
        if (at_mid)   samp_d[1] = rxd_sync_q;

        case (state_q)
            StIdle: begin
                phase_d   = '0;
                bit_cnt_d = '0;
                ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
                perr_d    = 1'b0;
`endif
                if (fall_q && rx_en) state_d = StStart;
            end
            StStart: begin
                if (at_last && vote) begin
                    state_d = StIdle;
                end else if (at_wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_last) data_d = {vote, data_q[DATA_BITS-1:1]};
                if (at_wrap) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (at_last) perr_d = vote ^ (^data_q) ^ PARITY_ODD;
                if (at_wrap) state_d = StStop;
            end
`endif
            StStop: begin
                if (at_last) begin
                    ferr_d = deliver_ferr;
                    // Leave at mid-bit of the last stop so the next start edge is caught.
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end
                end
                if (at_wrap) bit_cnt_d = bit_cnt_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase

        if (!rx_en) begin
            state_d = StIdle;
            deliver = 1'b0;
        end
    end

    assign load = deliver && (!dout_vld_q || dout_rdy);

    always_comb begin
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        dout_vld_d  = dout_vld_q;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (dout_vld_q && dout_rdy) dout_vld_d = 1'b0;
        if (load) begin
            dout_d      = data_q;
            frame_err_d = deliver_ferr;
            dout_vld_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            data_q      <= '0;
            ferr_q      <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            data_q      <= data_d;
            ferr_q      <= ferr_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= deliver && !load;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign parity_err = 1'b0;
`endif

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param; parity frames are exercised when UART_RX_PARITY_EN is set.
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
    localparam int unsigned DW = 7;
`else
    localparam int unsigned DW = 8;
`endif
    localparam int unsigned OS  = 16;
    localparam int unsigned CPT = 4;
    localparam int unsigned BP  = OS * CPT;
    localparam bit          PODD = 1'b0;

    typedef struct packed {
        logic [8:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic rx_en = 1'b1;
    logic dout_rdy = 1'b1;
    logic [DW-1:0] dout;
    logic dout_vld, frame_err, parity_err, overrun, busy;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_ovr = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS    (DW),
        .OVERSAMPLE   (OS),
        .CLKS_PER_TICK(CPT),
        .STOP_BITS    (1),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_en     (rx_en),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (!rst && dout_vld && dout_rdy) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("dout", 32'(dout), 32'(e.data));
                check_val("frame_err", 32'(frame_err), 32'(e.ferr));
                check_val("parity_err", 32'(parity_err), 32'(e.perr));
            end
        end
        if (!rst && overrun) n_ovr++;
    end

    task automatic drive_bit(input logic lvl);
        rxd = lvl;
        repeat (BP) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [8:0] data, input bit bad_par, input logic stop_lvl,
                              input bit expect_out);
        exp_t e;
        logic par;
        par = PODD;
        for (int i = 0; i < int'(DW); i++) par = par ^ data[i];
        e.data = data & 9'((1 << DW) - 1);
        e.ferr = ~stop_lvl;
`ifdef UART_RX_PARITY_EN
        e.perr = bad_par;
`else
        e.perr = 1'b0;
`endif
        if (expect_out) exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < int'(DW); i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par ^ bad_par);
`endif
        drive_bit(stop_lvl);
        drive_bit(1'b1);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_dout", 32'(dout), 32'h0);
        check_val("rst_vld", 32'(dout_vld), 32'h0);
        check_val("rst_ferr", 32'(frame_err), 32'h0);
        check_val("rst_perr", 32'(parity_err), 32'h0);
        check_val("rst_ovr", 32'(overrun), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        repeat (BP) @(posedge clk);
        #1;

        // Basic frame with busy observed mid-frame.
        fork
            send_frame(9'h0A5, 1'b0, 1'b1, 1'b1);
            begin
                repeat (5 * BP) @(posedge clk);
                @(negedge clk);
                check_val("busy_mid_frame", 32'(busy), 32'h1);
            end
        join
        @(negedge clk);
        check_val("busy_after_frame", 32'(busy), 32'h0);

        // Short glitch: false start, then a good frame.
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4 * CPT) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (BP) @(posedge clk);
        @(negedge clk);
        check_val("busy_false_start", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        send_frame(9'h03C, 1'b0, 1'b1, 1'b1);

        // Low stop bit -> framing error, word still delivered.
        send_frame(9'h055, 1'b0, 1'b0, 1'b1);

        // Break: two frames of low line -> one zero word with framing error.
        begin
            exp_t e;
            e.data = 9'h0;
            e.ferr = 1'b1;
            e.perr = 1'b0;
            exp_q.push_back(e);
        end
        rxd = 1'b0;
        repeat (2 * (DW + 3) * BP) @(posedge clk);
        @(negedge clk);
        check_val("busy_in_break", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Overrun: consumer stalled, second word dropped.
        dout_rdy = 1'b0;
        send_frame(9'h011, 1'b0, 1'b1, 1'b1);
        send_frame(9'h022, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("held_dout", 32'(dout), 32'h11);
        check_val("held_vld", 32'(dout_vld), 32'h1);
        @(posedge clk);
        #1 dout_rdy = 1'b1;
        @(posedge clk);
        #1 dout_rdy = 1'b0;
        @(negedge clk);
        check_val("vld_after_accept", 32'(dout_vld), 32'h0);

        // Reset in the middle of a frame while a word is held.
        send_frame(9'h077, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("vld_before_rst", 32'(dout_vld), 32'h1);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        @(negedge clk);
        check_val("busy_before_rst", 32'(busy), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst2_dout", 32'(dout), 32'h0);
        check_val("rst2_vld", 32'(dout_vld), 32'h0);
        check_val("rst2_ferr", 32'(frame_err), 32'h0);
        check_val("rst2_busy", 32'(busy), 32'h0);
        check_val("rst2_ovr", 32'(overrun), 32'h0);
        repeat (8 * BP) @(posedge clk);
        #1 dout_rdy = 1'b1;
        send_frame(9'h00F, 1'b0, 1'b1, 1'b1);

        // Receiver disabled mid-frame: abort, ignore the rest, then recover.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("busy_after_abort", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(DW); i++) drive_bit(i[0]);
        drive_bit(1'b1);
        rx_en = 1'b1;
        drive_bit(1'b1);
        send_frame(9'h05A, 1'b0, 1'b1, 1'b1);

`ifdef UART_RX_PARITY_EN
        send_frame(9'h041, 1'b0, 1'b1, 1'b1);
        send_frame(9'h041, 1'b1, 1'b1, 1'b1);
`endif

        repeat (2 * BP) @(posedge clk);
        @(negedge clk);
        check_val("words_outstanding", 32'(exp_q.size()), 32'h0);
        check_val("overrun_pulses", 32'(n_ovr), 32'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
